spi_controller: RTL and testbench

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_controller_if.sv | 36 +++
 rtl/spi_tick_gen.sv | 30 +++
 rtl/spi_controller.sv | 116 +++++++++++
 tb/tb_spi_controller.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI write controller: FSM states, frame width,
// peripheral register map and the frame builder.
package spi_pkg;

    localparam int unsigned FRAME_W = 16;

    localparam logic [6:0] EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] PWM_DUTY    = 7'h04;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HI,
        SCK_LO,
        GAP
    } state_e;

    // Write frame: R/W flag (1 = write), 7-bit address, 8-bit data, sent MSB first.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [6:0] addr,
                                                       input logic [7:0] wdata);
        return {1'b1, addr, wdata};
    endfunction

endpackage

// File: rtl/spi_controller_if.sv
// Request/SPI bus bundle for spi_controller; master is the controller side,
// slave is the requester/peripheral side.
interface spi_controller_if;

    logic       start;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       ready;
    logic       done;
    logic       SCLK;
    logic       COPI;
    logic       nCS;

    modport master (
        input  start,
        input  addr,
        input  wdata,
        output ready,
        output done,
        output SCLK,
        output COPI,
        output nCS
    );

    modport slave (
        output start,
        output addr,
        output wdata,
        input  ready,
        input  done,
        input  SCLK,
        input  COPI,
        input  nCS
    );

endinterface

// File: rtl/spi_tick_gen.sv
// Phase timer: one-cycle tick every CLK_DIV cycles, held at zero while i_clear is high
// so each frame starts with a full-length first phase.
module spi_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam logic [7:0] LP_LAST = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;
    logic       w_last;

    assign w_last = (r_cnt == LP_LAST);
    assign o_tick = w_last && !i_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_clear || w_last) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write-only controller: accepts a 7-bit address and 8-bit data, shifts out a
// 16-bit write frame MSB first, then holds chip select high for a guard gap.
module spi_controller
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_controller_if.master bus
);

    state_e             r_state;
    logic [4:0]         r_bit_cnt;
    logic [FRAME_W-1:0] r_shift;
    logic               r_ready;
    logic               r_done;
    logic               r_sclk;
    logic               r_copi;
    logic               r_ncs;

    logic               w_tick;
    logic               w_clear;
    logic [FRAME_W-1:0] w_frame;

    assign w_clear = (r_state == IDLE);
    assign w_frame = build_frame(bus.addr, bus.wdata);

    spi_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clear(w_clear),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= 5'd0;
            r_shift   <= '0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_copi    <= 1'b0;
            r_ncs     <= 1'b1;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state   <= SETUP;
                        r_shift   <= w_frame;
                        r_bit_cnt <= 5'd0;
                        r_ready   <= 1'b0;
                        r_ncs     <= 1'b0;
                        r_sclk    <= 1'b0;
                        r_copi    <= w_frame[FRAME_W-1];
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        r_state <= SCK_HI;
                        r_sclk  <= 1'b1;
                    end
                end
                SCK_HI: begin
                    // Advance data on the falling edge so it is stable at the next rise.
                    if (w_tick) begin
                        r_state   <= SCK_LO;
                        r_sclk    <= 1'b0;
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        r_shift   <= {r_shift[FRAME_W-2:0], 1'b0};
                        r_copi    <= r_shift[FRAME_W-2];
                    end
                end
                SCK_LO: begin
                    if (w_tick) begin
                        if (r_bit_cnt == 5'(FRAME_W)) begin
                            r_state <= GAP;
                            r_ncs   <= 1'b1;
                            r_copi  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= SCK_HI;
                            r_sclk  <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (w_tick) begin
                        r_state   <= IDLE;
                        r_ready   <= 1'b1;
                        r_bit_cnt <= 5'd0;
                        r_shift   <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_ncs   <= 1'b1;
                    r_sclk  <= 1'b0;
                    r_copi  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready = r_ready;
    assign bus.done  = r_done;
    assign bus.SCLK  = r_sclk;
    assign bus.COPI  = r_copi;
    assign bus.nCS   = r_ncs;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: default-divider instance with a behavioural register
// peripheral, plus a CLK_DIV=2 instance for back-to-back framing.
module tb_spi_controller;
    import spi_pkg::*;

    typedef struct {
        logic [15:0] frame;
        int          nbits;
        int          low;
        logic        done_at_end;
    } cap_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_n_b = 1'b0;
    always #5 clk = ~clk;

    spi_controller_if a_if ();
    spi_controller_if b_if ();

    spi_controller dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (a_if)
    );

    spi_controller #(
        .CLK_DIV(2)
    ) dut_b (
        .clk  (clk),
        .rst_n(rst_n_b),
        .bus  (b_if)
    );

    int n_chk = 0;
    int n_err = 0;

    // Peripheral model for instance A: shift on SCLK rise, commit write on nCS rise.
    logic [7:0]  a_regs [128] = '{default: 8'h00};
    cap_t        a_cap_q[$];
    logic [15:0] a_shift = '0;
    int          a_nbits = 0;
    int          a_low = 0;
    int          a_done_cnt = 0;
    int          a_frames = 0;
    logic        a_prev_sclk = 1'b0;
    logic        a_prev_ncs = 1'b1;

    always @(negedge clk) begin
        if (!rst_n) begin
            a_shift = '0;
            a_nbits = 0;
            a_low   = 0;
        end else begin
            if (a_if.SCLK && !a_prev_sclk && !a_if.nCS) begin
                a_shift = {a_shift[14:0], a_if.COPI};
                a_nbits++;
            end
            if (!a_if.nCS) a_low++;
            if (a_if.done) a_done_cnt++;
            if (a_if.nCS && !a_prev_ncs) begin
                a_cap_q.push_back('{a_shift, a_nbits, a_low, a_if.done});
                if (a_nbits == 16 && a_shift[15]) a_regs[a_shift[14:8]] = a_shift[7:0];
                a_frames++;
                a_shift = '0;
                a_nbits = 0;
                a_low   = 0;
            end
        end
        a_prev_sclk = a_if.SCLK;
        a_prev_ncs  = a_if.nCS;
    end

    // Instance B monitor: rising edges, nCS-low length and nCS-high gap per frame.
    int          b_edge_q[$];
    int          b_low_q[$];
    int          b_gap_q[$];
    logic [15:0] b_frame_q[$];
    logic [15:0] b_shift = '0;
    int          b_edges = 0;
    int          b_low = 0;
    int          b_high = 0;
    logic        b_seen_end = 1'b0;
    logic        b_prev_sclk = 1'b0;
    logic        b_prev_ncs = 1'b1;

    always @(negedge clk) begin
        if (rst_n_b) begin
            if (b_if.SCLK && !b_prev_sclk && !b_if.nCS) begin
                b_shift = {b_shift[14:0], b_if.COPI};
                b_edges++;
            end
            if (!b_if.nCS) b_low++;
            if (!b_if.nCS && b_prev_ncs && b_seen_end) b_gap_q.push_back(b_high);
            if (b_if.nCS && !b_prev_ncs) begin
                b_edge_q.push_back(b_edges);
                b_low_q.push_back(b_low);
                b_frame_q.push_back(b_shift);
                b_edges    = 0;
                b_low      = 0;
                b_high     = 1;
                b_seen_end = 1'b1;
            end else if (b_if.nCS) begin
                b_high++;
            end
        end
        b_prev_sclk = b_if.SCLK;
        b_prev_ncs  = b_if.nCS;
    end

    logic [15:0] exp_q[$];
    int          a_rd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!a_if.ready && n < 1000) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, a_if.ready, 1);
    endtask

    task automatic send(input string tag, input logic [6:0] addr, input logic [7:0] data,
                        input bit expect_frame);
        wait_ready(tag);
        a_if.start = 1'b1;
        a_if.addr  = addr;
        a_if.wdata = data;
        if (expect_frame) exp_q.push_back({1'b1, addr, data});
        tick();
        a_if.start = 1'b0;
        chk({tag, "_busy"}, a_if.ready, 0);
    endtask

    task automatic wait_frame(input string tag);
        int          n = 0;
        cap_t        c;
        logic [15:0] e;
        while (a_cap_q.size() <= a_rd && n < 3000) begin
            tick();
            n++;
        end
        if (a_cap_q.size() <= a_rd) begin
            chk({tag, "_timeout"}, a_cap_q.size(), a_rd + 1);
        end else begin
            c = a_cap_q[a_rd];
            a_rd++;
            e = exp_q.pop_front();
            chk({tag, "_frame"}, c.frame, e);
            chk({tag, "_nbits"}, c.nbits, 16);
            chk({tag, "_ncs_low"}, c.low, 132);
            chk({tag, "_done_at_end"}, c.done_at_end, 1);
        end
    endtask

    initial begin
        int d0;
        int f0;
        int n;
        a_if.start = 1'b0;
        a_if.addr  = '0;
        a_if.wdata = '0;
        b_if.start = 1'b0;
        b_if.addr  = '0;
        b_if.wdata = '0;
        repeat (3) tick();
        chk("rst_ncs", a_if.nCS, 1);
        chk("rst_sclk", a_if.SCLK, 0);
        chk("rst_copi", a_if.COPI, 0);
        chk("rst_done", a_if.done, 0);
        chk("rst_ready", a_if.ready, 1);
        rst_n   = 1'b1;
        rst_n_b = 1'b1;
        repeat (2) tick();

        // Basic frame, then idle outputs.
        d0 = a_done_cnt;
        send("f00ff", EN_OUT_7_0, 8'hFF, 1'b1);
        wait_frame("f00ff");
        wait_ready("f00ff_idle");
        chk("idle_sclk", a_if.SCLK, 0);
        chk("idle_copi", a_if.COPI, 0);
        chk("idle_ncs", a_if.nCS, 1);
        chk("idle_done", a_if.done, 0);
        chk("f00ff_done_cnt", a_done_cnt - d0, 1);
        chk("reg_out_7_0", a_regs[EN_OUT_7_0], 8'hFF);

        // Register writes through the peripheral model.
        send("duty", PWM_DUTY, 8'h80, 1'b1);
        wait_frame("duty");
        send("pwm", EN_PWM_7_0, 8'h01, 1'b1);
        wait_frame("pwm");
        chk("reg_pwm_duty", a_regs[PWM_DUTY], 8'h80);
        chk("reg_en_pwm_7_0", a_regs[EN_PWM_7_0], 8'h01);

        // Starts during a frame are ignored.
        d0 = a_done_cnt;
        f0 = a_frames;
        send("ign", EN_OUT_15_8, 8'hC3, 1'b1);
        for (int i = 1; i <= 120; i++) begin
            a_if.start = (i == 10 || i == 50 || i == 100);
            a_if.addr  = 7'h7F;
            a_if.wdata = 8'h11;
            tick();
        end
        a_if.start = 1'b0;
        wait_frame("ign");
        repeat (20) tick();
        chk("ign_frames", a_frames - f0, 1);
        chk("ign_done_cnt", a_done_cnt - d0, 1);

        // Input changes after acceptance do not affect the frame.
        send("hold", 7'h01, 8'hAA, 1'b1);
        repeat (30) tick();
        a_if.addr  = 7'h7F;
        a_if.wdata = 8'h55;
        wait_frame("hold");

        // Reset at the 8th SCLK rising edge aborts without done or register write.
        d0 = a_done_cnt;
        f0 = a_frames;
        send("abort", PWM_DUTY, 8'h33, 1'b0);
        n = 0;
        while (a_nbits < 8 && n < 1000) begin
            tick();
            n++;
        end
        chk("abort_at_edge8", a_nbits, 8);
        rst_n = 1'b0;
        #1;
        chk("abort_ncs", a_if.nCS, 1);
        chk("abort_sclk", a_if.SCLK, 0);
        chk("abort_copi", a_if.COPI, 0);
        chk("abort_ready", a_if.ready, 1);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("abort_done_cnt", a_done_cnt - d0, 0);
        chk("abort_frames", a_frames - f0, 0);
        chk("abort_reg_kept", a_regs[PWM_DUTY], 8'h80);
        send("fresh", EN_PWM_15_8, 8'h5A, 1'b1);
        wait_frame("fresh");
        chk("fresh_reg", a_regs[EN_PWM_15_8], 8'h5A);

        // Back-to-back frames on the CLK_DIV=2 instance.
        b_if.addr  = 7'h12;
        b_if.wdata = 8'h34;
        b_if.start = 1'b1;
        n = 0;
        while (b_edge_q.size() < 3 && n < 2000) begin
            tick();
            n++;
        end
        b_if.start = 1'b0;
        repeat (20) tick();
        chk("b2b_frames", b_edge_q.size(), 3);
        chk("b2b_gaps", b_gap_q.size(), 2);
        for (int i = 0; i < b_edge_q.size(); i++) begin
            chk($sformatf("b2b_edges%0d", i), b_edge_q[i], 16);
            chk($sformatf("b2b_low%0d", i), b_low_q[i], 66);
            chk($sformatf("b2b_frame%0d", i), b_frame_q[i], 16'h9234);
        end
        for (int i = 0; i < b_gap_q.size(); i++) begin
            chk($sformatf("b2b_gap%0d", i), b_gap_q[i], 3);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
